// File: rtl/shared_mem_bus_pkg.sv
// Shared types and helpers for the shared-memory interconnect.
package shared_mem_bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Width of a port index. It is never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_mem_bus_rr_arbiter.sv
// Combinational round-robin picker. The search starts one past last_gnt
// and wraps. The grant and index registers live in the parent.
module rr_arbiter
  import shared_mem_bus_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Take the first requester found above last_gnt, wrapping at N.
  always_comb begin
    logic          found;
    logic [IW-1:0] p;
    found   = 1'b0;
    p       = '0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 1; k <= N; k++) begin
      p = IW'((int'(last_gnt) + k) % N);
      if (!found && req[p]) begin
        found   = 1'b1;
        gnt[p]  = 1'b1;
        gnt_idx = p;
      end
    end
  end

endmodule

// File: rtl/shared_mem_bus.sv
// N-port shared-memory interconnect. A round-robin grant is held until the
// memory completes. Reads return a tagged response one cycle after completion.
// Each completed write is broadcast as a snoop to every other port.
module shared_mem_bus
  import shared_mem_bus_pkg::*;
#(
  parameter  int N_PORTS = 4,
  parameter  int ADDR_W  = 8,
  parameter  int DATA_W  = 8,
  localparam int IW      = idx_w(N_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_rd,
  input  logic [N_PORTS-1:0]          req_wr,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
  output logic [N_PORTS-1:0]          req_rdy,
  output logic [N_PORTS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [N_PORTS-1:0]          snp_valid,
  output logic [ADDR_W-1:0]           snp_addr,
  output logic [DATA_W-1:0]           snp_wdata,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_rdy,
  input  logic [DATA_W-1:0]           mem_rdata
);

  state_e               state_q, state_d;
  logic [N_PORTS-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        last_q, last_d;
  logic [N_PORTS-1:0]   rsp_valid_q;
  logic [N_PORTS-1:0]   snp_valid_q;
  logic [ADDR_W-1:0]    snp_addr_q;
  logic [DATA_W-1:0]    snp_wdata_q;

  logic [N_PORTS-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 g_rd, g_wr, rd_done, wr_done;

  rr_arbiter #(.N(N_PORTS)) u_arb (
    .req      (req_rd | req_wr),
    .last_gnt (last_q),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  // Next state and memory-side drive.
  // A request with both rd and wr set is treated as a write.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    g_rd      = 1'b0;
    g_wr      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    req_rdy   = '0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|(req_rd | req_wr)) begin
          state_d = ST_BUSY;
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          last_d  = arb_idx;
        end
      end
      ST_BUSY: begin
        g_wr      = req_wr[idx_q];
        g_rd      = req_rd[idx_q] & ~g_wr;
        mem_rd    = g_rd;
        mem_wr    = g_wr;
        mem_addr  = req_addr[idx_q*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[idx_q*DATA_W +: DATA_W];
        if (!(g_rd || g_wr)) begin
          // The requester dropped out before completion. Release the bus silently.
          state_d = ST_IDLE;
        end else if (mem_rdy) begin
          req_rdy = gnt_q;
          state_d = ST_IDLE;
          rd_done = g_rd;
          wr_done = g_wr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant, and the one-cycle response and snoop strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      idx_q       <= '0;
      last_q      <= IW'(N_PORTS - 1);
      rsp_valid_q <= '0;
      snp_valid_q <= '0;
      snp_addr_q  <= '0;
      snp_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      rsp_valid_q <= rd_done ? gnt_q : '0;
      snp_valid_q <= wr_done ? ~gnt_q : '0;
      if (wr_done) begin
        snp_addr_q  <= mem_addr;
        snp_wdata_q <= mem_wdata;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = (|rsp_valid_q) ? mem_rdata : '0;
  assign snp_valid = snp_valid_q;
  assign snp_addr  = snp_addr_q;
  assign snp_wdata = snp_wdata_q;

endmodule

// File: tb/tb_shared_mem_bus.sv
// Directed bench for shared_mem_bus with 4 ports and 8-bit address and data.
module tb_shared_mem_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_rd, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_rdy, rsp_valid, snp_valid;
  logic [7:0]  rsp_rdata, snp_addr, snp_wdata;
  logic        mem_rd, mem_wr, mem_rdy;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  shared_mem_bus #(.N_PORTS(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdy(req_rdy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .snp_valid(snp_valid), .snp_addr(snp_addr), .snp_wdata(snp_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_rd = '0; req_wr = '0; mem_rdy = 1'b0; mem_rdata = 8'h00;
    req_addr  = {8'h33, 8'h10, 8'h20, 8'h40};
    req_wdata = {8'h00, 8'h00, 8'h3C, 8'h00};
    tick(); #1;
    checks++; if ({req_rdy, rsp_valid, snp_valid} !== 12'h000) begin errors++; $display("FAIL reset_strobes got %h want 000", {req_rdy, rsp_valid, snp_valid}); end
    checks++; if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== 18'h0) begin errors++; $display("FAIL reset_mem got %h want 0", {mem_rd, mem_wr, mem_addr, mem_wdata}); end
    checks++; if ({snp_addr, snp_wdata, rsp_rdata} !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 0", {snp_addr, snp_wdata, rsp_rdata}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    int cnt [4];
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    req_rd = 4'hF; rst = 1'b0;   // cycle 0
    for (int c = 1; c <= 16; c++) begin
      tick();
      mem_rdy = mem_rd; mem_rdata = 8'(c);
      #1;
      exp = (c % 2 == 1) ? 4'(1 << (((c - 1) / 2) % 4)) : 4'b0000;
      checks++; if (req_rdy !== exp) begin errors++; $display("FAIL rr_rdy c=%0d got %b want %b", c, req_rdy, exp); end
      for (int i = 0; i < 4; i++) if (req_rdy[i]) cnt[i]++;
      if (c % 2 == 0) begin
        exp = 4'(1 << (((c - 2) / 2) % 4));
        checks++; if (rsp_valid !== exp || rsp_rdata !== 8'(c)) begin errors++; $display("FAIL rr_rsp c=%0d got %b/%h want %b/%h", c, rsp_valid, rsp_rdata, exp, 8'(c)); end
      end
    end
    req_rd = '0; mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cnt[i] !== 2) begin errors++; $display("FAIL rr_count port%0d got %0d want 2", i, cnt[i]); end
    end
  endtask

  task automatic test_write();
    tick(); req_wr = 4'b0010; req_rd = 4'b0010;   // both set, so it is a write
    tick();
    checks++; if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {1'b1, 1'b0, 8'h20, 8'h3C}) begin errors++; $display("FAIL wr_mem got %b%b %h %h want 10 20 3c", mem_wr, mem_rd, mem_addr, mem_wdata); end
    mem_rdy = 1'b1; #1;
    checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL wr_rdy got %b want 0010", req_rdy); end
    tick(); mem_rdy = 1'b0; req_wr = '0; req_rd = '0; #1;
    checks++; if ({snp_valid, snp_addr, snp_wdata} !== {4'b1101, 8'h20, 8'h3C}) begin errors++; $display("FAIL wr_snoop got %b %h %h want 1101 20 3c", snp_valid, snp_addr, snp_wdata); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_norsp got %b want 0000", rsp_valid); end
    tick();
    checks++; if ({snp_valid, snp_addr} !== {4'b0000, 8'h20}) begin errors++; $display("FAIL wr_snoop_end got %b %h want 0000 20", snp_valid, snp_addr); end
  endtask

  task automatic test_wait_states();
    tick(); req_rd = 4'b1001;   // ports 3 and 0; port 3 is next in rotation
    for (int c = 1; c <= 4; c++) begin
      tick();
      mem_rdy = (c == 4); #1;
      checks++; if ({mem_rd, mem_addr} !== {1'b1, 8'h33}) begin errors++; $display("FAIL ws_mem c=%0d got %b %h want 1 33", c, mem_rd, mem_addr); end
      checks++; if (req_rdy !== ((c == 4) ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL ws_rdy c=%0d got %b", c, req_rdy); end
    end
    tick(); mem_rdy = 1'b0; req_rd = 4'b0001; mem_rdata = 8'h77; #1;
    checks++; if ({rsp_valid, rsp_rdata, mem_rd} !== {4'b1000, 8'h77, 1'b0}) begin errors++; $display("FAIL ws_rsp got %b %h %b want 1000 77 0", rsp_valid, rsp_rdata, mem_rd); end
    tick(); mem_rdy = 1'b1; #1;
    checks++; if ({mem_addr, req_rdy} !== {8'h40, 4'b0001}) begin errors++; $display("FAIL ws_next got %h %b want 40 0001", mem_addr, req_rdy); end
    tick(); mem_rdy = 1'b0; req_rd = '0;
  endtask

  task automatic test_single_read();
    tick(); req_rd = 4'b0100; #1;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL sr_idle got %b want 0", mem_rd); end
    tick();
    checks++; if ({mem_rd, mem_addr, req_rdy} !== {1'b1, 8'h10, 4'b0000}) begin errors++; $display("FAIL sr_mem got %b %h %b want 1 10 0000", mem_rd, mem_addr, req_rdy); end
    mem_rdy = 1'b1; #1;
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL sr_rdy got %b want 0100", req_rdy); end
    tick(); mem_rdy = 1'b0; req_rd = '0; mem_rdata = 8'hA5; #1;
    checks++; if ({rsp_valid, rsp_rdata} !== {4'b0100, 8'hA5}) begin errors++; $display("FAIL sr_rsp got %b %h want 0100 a5", rsp_valid, rsp_rdata); end
    tick();
    checks++; if ({rsp_valid, rsp_rdata} !== {4'b0000, 8'h00}) begin errors++; $display("FAIL sr_rsp_end got %b %h want 0000 00", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_abort();
    tick(); req_rd = 4'b0001;
    tick();
    checks++; if ({mem_rd, mem_addr} !== {1'b1, 8'h40}) begin errors++; $display("FAIL ab_mem got %b %h want 1 40", mem_rd, mem_addr); end
    req_rd = '0; #1;
    checks++; if ({mem_rd, req_rdy} !== 5'b0) begin errors++; $display("FAIL ab_drop got %b %b want 0 0000", mem_rd, req_rdy); end
    tick(); req_rd = 4'b0011; #1;
    checks++; if ({mem_rd, rsp_valid, snp_valid} !== 9'b0) begin errors++; $display("FAIL ab_quiet got %b %b %b want all 0", mem_rd, rsp_valid, snp_valid); end
    tick(); mem_rdy = 1'b1; #1;
    checks++; if ({mem_addr, req_rdy} !== {8'h20, 4'b0010}) begin errors++; $display("FAIL ab_next got %h %b want 20 0010", mem_addr, req_rdy); end
    tick(); mem_rdy = 1'b0; req_rd = '0;
  endtask

  task automatic test_reset_mid();
    tick(); req_rd = 4'b0100;
    tick();
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rm_busy got %b want 1", mem_rd); end
    mem_rdy = 1'b1; rst = 1'b1; #1;
    checks++; if ({mem_rd, mem_addr, req_rdy} !== 13'b0) begin errors++; $display("FAIL rm_async got %b %h %b want 0", mem_rd, mem_addr, req_rdy); end
    tick(); #1;
    checks++; if ({rsp_valid, snp_valid} !== 8'b0) begin errors++; $display("FAIL rm_norsp got %b %b want 0", rsp_valid, snp_valid); end
    mem_rdy = 1'b0; req_rd = 4'b0101; rst = 1'b0;
    tick(); mem_rdy = 1'b1; #1;
    checks++; if ({mem_rd, mem_addr, req_rdy} !== {1'b1, 8'h40, 4'b0001}) begin errors++; $display("FAIL rm_prio got %b %h %b want 1 40 0001", mem_rd, mem_addr, req_rdy); end
    tick(); mem_rdy = 1'b0; req_rd = '0; #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rm_rsp got %b want 0001", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write();
    test_wait_states();
    test_single_read();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
